// File: rtl/stage3_if.sv
// stage3 candidate/result bundle: upstream accept handshake,
// per-cycle study inputs and downstream result handshake.
interface stage3_if;
    logic       in_valid;
    logic       in_ready;
    logic       pass2;
    logic [1:0] bonus2;
    logic [6:0] hard;
    logic [6:0] effort;
    logic [1:0] luck;
    logic       out_valid;
    logic       out_ready;
    logic       pass3;
    logic [1:0] grade;
    logic [1:0] tries;

    modport master (
        output in_valid, pass2, bonus2, hard, effort, luck, out_ready,
        input  in_ready, out_valid, pass3, grade, tries
    );

    modport slave (
        input  in_valid, pass2, bonus2, hard, effort, luck, out_ready,
        output in_ready, out_valid, pass3, grade, tries
    );
endinterface

// File: rtl/stage3.sv
// stage3: final exam. Studies over a fixed window, sits an exam
// against a latched difficulty, retries, then reports the verdict.
module stage3 #(
    parameter int STUDY_LOG2 = 2,
    parameter int MAX_TRY    = 3,
    parameter int PASS_MARK  = 70
) (
    input logic     clk,
    input logic     rst,
    stage3_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        STUDY,
        EXAM,
        DONE
    } state_t;

    state_t                  state;
    logic [8:0]              acc;
    logic [STUDY_LOG2-1:0]   cnt;
    logic [1:0]              bonus_l;
    logic [6:0]              hard_l;
    logic                    pass3_r;
    logic [1:0]              grade_r;
    logic [1:0]              tries_r;

    logic [8:0]              raw;
    logic [6:0]              score;
    logic [6:0]              margin;
    logic [1:0]              grade_n;
    logic [1:0]              tries_n;
    logic                    good;

    // Exam scoring from the window average, bonus and this cycle's luck.
    always_comb begin
        raw = (acc >> STUDY_LOG2)
            + {5'd0, bonus_l, 2'b00}
            + {5'd0, bus.luck, 2'b00};
        score = (raw > 9'd100) ? 7'd100 : raw[6:0];
        margin = (score - 7'(PASS_MARK)) >> 3;
        grade_n = (margin > 7'd3) ? 2'd3 : margin[1:0];
        tries_n = tries_r + 2'd1;
        good = (score >= 7'(PASS_MARK)) && (score >= hard_l);
    end

    // Control FSM with registered verdict outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            bonus_l <= '0;
            hard_l  <= '0;
            pass3_r <= 1'b0;
            grade_r <= '0;
            tries_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bonus_l <= bus.bonus2;
                        hard_l  <= bus.hard;
                        pass3_r <= 1'b0;
                        grade_r <= '0;
                        tries_r <= '0;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= bus.pass2 ? STUDY : DONE;
                    end
                end
                STUDY: begin
                    acc <= acc + {2'b00, bus.effort};
                    cnt <= cnt + STUDY_LOG2'(1);
                    if (cnt == '1) begin
                        state <= EXAM;
                    end
                end
                EXAM: begin
                    tries_r <= tries_n;
                    acc     <= '0;
                    cnt     <= '0;
                    if (good) begin
                        pass3_r <= 1'b1;
                        grade_r <= grade_n;
                        state   <= DONE;
                    end else if (tries_n == 2'(MAX_TRY)) begin
                        state <= DONE;
                    end else begin
                        state <= STUDY;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.pass3     = pass3_r;
    assign bus.grade     = grade_r;
    assign bus.tries     = tries_r;
endmodule

// File: tb/tb_stage3.sv
// Randomized scoreboard bench for stage3: driver pushes modelled
// verdicts and due cycles; a monitor pops and checks each result.
module tb_stage3;
    localparam int MAX_TRY = 3;
    localparam int PASS    = 70;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    stage3_if bus ();

    stage3 #(
        .STUDY_LOG2(2),
        .MAX_TRY   (MAX_TRY),
        .PASS_MARK (PASS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p3;
        int gr;
        int tr;
        int due;
        int hold;
    } exp_t;

    exp_t q[$];
    int   ea[15];
    int   la[3];

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    task automatic set_eff(input int v);
        for (int i = 0; i < 15; i++) ea[i] = v;
    endtask

    task automatic set_luck(input int a, input int b, input int c);
        la[0] = a;
        la[1] = b;
        la[2] = c;
    endtask

    // One candidate: model the verdict, accept, feed effort/luck.
    task automatic run(input int p2, input int b, input int h,
                       input int hold, input int junk);
        exp_t e;
        int   n;
        int   g;
        int   j;
        int   sc;
        bit   fin;
        e.p3 = 0;
        e.gr = 0;
        e.tr = 0;
        e.hold = hold;
        fin = 0;
        if (p2 != 0) begin
            e.tr = MAX_TRY;
            for (int a = 0; a < MAX_TRY; a++) begin
                if (!fin) begin
                    sc = (ea[5*a] + ea[5*a+1] + ea[5*a+2] + ea[5*a+3]) / 4
                       + 4 * b + 4 * la[a];
                    if (sc > 100) sc = 100;
                    if (sc >= PASS && sc >= h) begin
                        e.p3 = 1;
                        e.gr = (sc - PASS) / 8;
                        if (e.gr > 3) e.gr = 3;
                        e.tr = a + 1;
                        fin = 1;
                    end
                end
            end
        end
        g = 0;
        while (!bus.in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!bus.in_ready) begin
            chk("wait_in_ready", 0, 1);
        end else begin
            bus.in_valid = 1'b1;
            bus.pass2    = 1'(p2);
            bus.bonus2   = 2'(b);
            bus.hard     = 7'(h);
            bus.effort   = 7'(ea[0]);
            bus.luck     = 2'(la[0]);
            @(posedge clk);
            #1;
            n = cyc;
            e.due = n + 5 * e.tr;
            q.push_back(e);
            j = 0;
            g = 0;
            while (!bus.in_ready && g < 100) begin
                bus.in_valid = 1'(junk);
                if (junk != 0) begin
                    bus.pass2 = 1'($urandom);
                    bus.hard  = 7'($urandom_range(0, 100));
                end
                if (j < 15) begin
                    bus.effort = 7'(ea[j]);
                    bus.luck   = 2'(la[j/5]);
                end
                @(posedge clk);
                #1;
                j++;
                g++;
            end
            if (!bus.in_ready) chk("result_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end
    endtask

    // Monitor: pop and compare each presented result, apply backpressure.
    initial begin
        exp_t e;
        int   snap;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc, e.due);
                    chk("pass3", int'(bus.pass3), e.p3);
                    chk("grade", int'(bus.grade), e.gr);
                    chk("tries", int'(bus.tries), e.tr);
                    chk("in_ready_done", int'(bus.in_ready), 0);
                    snap = int'({bus.out_valid, bus.pass3, bus.grade,
                                 bus.tries, bus.in_ready});
                    for (int i = 0; i < e.hold; i++) begin
                        @(negedge clk);
                        chk("hold_stable",
                            int'({bus.out_valid, bus.pass3, bus.grade,
                                  bus.tries, bus.in_ready}), snap);
                    end
                end
                bus.out_ready = 1'b1;
                @(negedge clk);
                bus.out_ready = 1'b0;
                chk("idle_out_valid", int'(bus.out_valid), 0);
                chk("idle_in_ready", int'(bus.in_ready), 1);
            end
        end
    end

    initial begin
        int g;
        bus.in_valid = 1'b0;
        bus.pass2    = 1'b0;
        bus.bonus2   = '0;
        bus.hard     = '0;
        bus.effort   = '0;
        bus.luck     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_pass3", int'(bus.pass3), 0);
        chk("rst_grade", int'(bus.grade), 0);
        chk("rst_tries", int'(bus.tries), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_luck(0, 0, 0);
        set_eff(80);  run(1, 1, 50, 0, 0);
        set_eff(33);  run(0, 3, 0, 1, 0);
        set_eff(60);  run(1, 0, 10, 0, 0);
        set_luck(3, 3, 3);
        set_eff(100); run(1, 3, 100, 0, 0);
        set_luck(0, 2, 0);
        set_eff(90);  run(1, 0, 95, 0, 0);
        set_luck(0, 0, 0);
        set_eff(72);  run(1, 0, 72, 0, 0);
        set_eff(70);  run(1, 0, 0, 0, 0);
        set_eff(69);  run(1, 0, 0, 0, 0);
        set_luck(3, 3, 3);
        set_eff(100); run(1, 3, 101, 0, 0);
        set_luck(0, 0, 0);
        set_eff(80);  run(1, 1, 50, 5, 1);
        set_eff(80);  run(1, 2, 60, 0, 0);

        g = 0;
        while (!bus.in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        bus.in_valid = 1'b1;
        bus.pass2    = 1'b1;
        bus.bonus2   = 2'd0;
        bus.hard     = 7'd0;
        bus.effort   = 7'd50;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        chk("mid_rst_pass3", int'(bus.pass3), 0);
        chk("mid_rst_grade", int'(bus.grade), 0);
        chk("mid_rst_tries", int'(bus.tries), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_luck(0, 0, 0);
        set_eff(80);  run(1, 1, 50, 0, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 15; i++) ea[i] = $urandom_range(40, 100);
            set_luck($urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3));
            run(($urandom_range(0, 4) != 0) ? 1 : 0,
                $urandom_range(0, 3), $urandom_range(30, 110),
                $urandom_range(0, 3), $urandom_range(0, 1));
        end

        g = 0;
        while ((q.size() != 0 || bus.out_valid) && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stage3.md
Name: stage3

Overview:
- Final-exam stage, directly downstream of stage2; consumes its pass2/bonus2 verdict.
- Accepts one candidate per handshake, then accumulates effort over a fixed study window.
- Runs an exam against a latched difficulty and retries up to MAX_TRY times.
- Returns pass3/grade/tries through a valid/ready output handshake.

Parameters:
- STUDY_LOG2, 2, log2 of study-window length in cycles (window = 4 cycles).
- MAX_TRY, 3, maximum exam attempts (1..3; tries output is 2 bits).
- PASS_MARK, 70, minimum score to pass (0..100).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream candidate valid.
- in_ready  output  1  block can accept a candidate.
- pass2  input  1  stage2 pass flag, sampled on accept.
- bonus2  input  2  stage2 bonus, sampled on accept.
- hard  input  7  exam difficulty 0..100, sampled on accept.
- effort  input  7  per-cycle effort 0..100, sampled every STUDY cycle.
- luck  input  2  luck, sampled in the EXAM cycle only.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- pass3  output  1  final pass flag.
- grade  output  2  pass quality 0..3; 0 on fail.
- tries  output  2  exam attempts used; 0 when pass2 was 0.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - Outputs: out_valid=0, pass3=0, grade=0, tries=0.
  - Internals cleared: accumulator, cycle counter, latches.
  - Assertion in any state aborts the operation in progress; nothing is emitted.
- States: IDLE, STUDY, EXAM, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE:
  - On in_valid&in_ready, latch pass2, bonus2 and hard.
  - If pass2=0: go to DONE with pass3=0, grade=0, tries=0.
  - Otherwise: go to STUDY with acc=0, cnt=0, tries=0.
- STUDY:
  - Each cycle: acc += effort (9-bit acc, max 400, no overflow); cnt++.
  - After 2^STUDY_LOG2 cycles, go to EXAM.
- EXAM (one cycle):
  - avg = acc >> STUDY_LOG2 (7 bits).
  - raw = avg + 4*bonus2_latched + 4*luck (8 bits, max 124).
  - score = min(raw, 100).
  - tries increments.
  - Pass condition: score >= PASS_MARK AND score >= hard_latched.
  - On pass: go to DONE with pass3=1 and grade = min((score-PASS_MARK)>>3, 3).
  - On fail with tries < MAX_TRY: go back to STUDY with acc=0, cnt=0.
  - On fail with tries = MAX_TRY: go to DONE with pass3=0, grade=0.
- DONE:
  - pass3, grade and tries are registered and held stable while out_valid=1.
  - On out_ready=1, go to IDLE and drop out_valid next cycle.
  - in_valid is ignored outside IDLE; no input is lost because in_ready=0.
- Latency, accept at cycle T:
  - pass2=0: out_valid at T+1.
  - Pass on attempt k: out_valid at T+1+5k.
  - MAX_TRY failures: out_valid at T+1+5*MAX_TRY.
- Boundaries:
  - score == hard or score == PASS_MARK counts as a pass.
  - hard > 100 can never be passed.
  - effort and luck changing mid-window are used exactly as sampled.
  - Simultaneous out_ready and in_valid in DONE: the new candidate is not accepted until the IDLE cycle.

Test Plan:
- Nominal pass: pass2=1, bonus2=1, hard=50, effort=80 constant, luck=0 -> score 84; out_valid at T+6 with pass3=1, grade=1, tries=1.
- Upstream fail: pass2=0, any other inputs -> out_valid at T+1 with pass3=0, grade=0, tries=0; no STUDY cycles occur.
- Exhausted retries: pass2=1, bonus2=0, hard=10, effort=60, luck=0 -> score 60 on every attempt; out_valid at T+16 with pass3=0, grade=0, tries=3.
- Saturation and retry on difficulty:
  - effort=100, bonus2=3, luck=3 -> raw 124 capped to 100; pass3=1, grade=3, tries=1.
  - effort=90, bonus2=0, hard=95, luck=0 then luck=2 in the second EXAM -> first attempt 90 fails, second attempt 98 passes; pass3=1, grade=3, tries=2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no new accept; after out_ready=1, IDLE follows and the next candidate is accepted one cycle later.
- Reset mid-operation: assert rst during the 2nd STUDY cycle -> immediately state IDLE, out_valid=0, pass3=0, grade=0, tries=0; a fresh candidate after release completes normally.
